mc_controller: RTL and testbench

- Multi-cycle FSM controller that sequences the shared MIPS datapath: one ALU, one memory port, one GRF write port.
- Sits beside the datapath in the top-level CPU.
- Decodes opcode/funct latched in IR, steps FETCH/DECODE/EXE/MEM/WB, and drives per-cycle write enables and muxes.
- Keeps a retired-instruction counter.

---
 rtl/mc_controller_pkg.sv | 78 +++++++
 rtl/mc_controller_if.sv | 31 +++
 rtl/mc_controller_decode.sv | 36 +++
 rtl/mc_controller.sv | 207 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and its datapath:
// ISA opcode/funct constants, FSM state encoding, mux-select encodings and
// the one-hot instruction flag bundle produced by the decoder.
package mc_controller_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;

  // Primary opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

  // R-type function codes (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_JR   = 6'b001000;

  // FSM states; HALT is only reachable with the illegal-halt build option
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Next-PC select
  localparam logic [SEL_W-1:0] NPC_PC4    = 2'b00;
  localparam logic [SEL_W-1:0] NPC_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] NPC_JAL    = 2'b10;
  localparam logic [SEL_W-1:0] NPC_JR     = 2'b11;

  // ALU operation
  localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OR  = 2'b10;
  localparam logic [SEL_W-1:0] ALU_XOR = 2'b11;

  // GRF write-address select
  localparam logic [SEL_W-1:0] A3_RD = 2'b00;
  localparam logic [SEL_W-1:0] A3_RT = 2'b01;
  localparam logic [SEL_W-1:0] A3_RA = 2'b10;

  // GRF write-data select
  localparam logic [SEL_W-1:0] WD_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WD_DM  = 2'b01;
  localparam logic [SEL_W-1:0] WD_PC  = 2'b10;
  localparam logic [SEL_W-1:0] WD_LUI = 2'b11;

  // One-hot instruction classification; exactly one bit set for any IR
  typedef struct packed {
    logic addu;
    logic subu;
    logic is_xor;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic lui;
    logic illegal;
  } instr_flags_t;

  function automatic logic is_rtype_alu(instr_flags_t f);
    return f.addu | f.subu | f.is_xor;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
// master: controller (consumes IR fields / Equ, drives enables and selects)
// slave : datapath   (drives IR fields / Equ, consumes enables and selects)
interface mc_controller_if;

  logic [mc_controller_pkg::OP_W-1:0]    opcode;
  logic [mc_controller_pkg::FUNCT_W-1:0] funct;
  logic                                  Equ;

  logic                                  PCWr;
  logic                                  IRWr;
  logic [mc_controller_pkg::SEL_W-1:0]   NPCOp;
  logic                                  GRFWr;
  logic                                  EXTOp;
  logic [mc_controller_pkg::SEL_W-1:0]   ALUOp;
  logic                                  BSel;
  logic                                  DMWr;
  logic [mc_controller_pkg::SEL_W-1:0]   A3Sel;
  logic [mc_controller_pkg::SEL_W-1:0]   WDSel;

  modport master (
    input  opcode, funct, Equ,
    output PCWr, IRWr, NPCOp, GRFWr, EXTOp, ALUOp, BSel, DMWr, A3Sel, WDSel
  );

  modport slave (
    output opcode, funct, Equ,
    input  PCWr, IRWr, NPCOp, GRFWr, EXTOp, ALUOp, BSel, DMWr, A3Sel, WDSel
  );

endinterface

// File: rtl/mc_controller_decode.sv
// Combinational instruction decoder: IR opcode/funct to one-hot flags.
// Ports:
//   opcode - IR[31:26]
//   funct  - IR[5:0], only meaningful for R-type opcode
//   instr  - one-hot instruction class, 'illegal' for anything unsupported
module mc_controller_decode
  import mc_controller_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output instr_flags_t       instr
);

  always_comb begin
    instr = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: instr.addu    = 1'b1;
          FN_SUBU: instr.subu    = 1'b1;
          FN_XOR:  instr.is_xor  = 1'b1;
          FN_JR:   instr.jr      = 1'b1;
          default: instr.illegal = 1'b1;
        endcase
      end
      OP_ORI:  instr.ori     = 1'b1;
      OP_LW:   instr.lw      = 1'b1;
      OP_SW:   instr.sw      = 1'b1;
      OP_BEQ:  instr.beq     = 1'b1;
      OP_JAL:  instr.jal     = 1'b1;
      OP_LUI:  instr.lui     = 1'b1;
      default: instr.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle FSM controller sequencing a shared-ALU MIPS datapath through
// FETCH/DECODE/EXE/MEM/WB, with a retired-instruction counter.
// Build option: MC_CTRL_ILLEGAL_HALT_EN - illegal instructions park the FSM
// in HALT (left only by reset) and a 'halted' output is added; otherwise an
// illegal instruction is a NOP.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-low reset
//   bus     - control bus (IR fields and Equ in; enables and selects out)
//   state   - current FSM state (debug)
//   retired - instructions completed since reset, wraps modulo 2^CNT_W
//   halted  - (option only) FSM is parked in HALT
// Enables/selects are Moore decodes of the current state and the latched IR,
// forced to zero while reset is asserted.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mc_controller_if.master    bus,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired
`ifdef MC_CTRL_ILLEGAL_HALT_EN
  ,
  output logic               halted
`endif
);

  state_e       state_q;
  state_e       state_d;
  instr_flags_t instr;
  logic         retire_c;

  logic             pc_wr;
  logic             ir_wr;
  logic [SEL_W-1:0] npc_op;
  logic             grf_wr;
  logic             ext_op;
  logic [SEL_W-1:0] alu_op;
  logic             b_sel;
  logic             dm_wr;
  logic [SEL_W-1:0] a3_sel;
  logic [SEL_W-1:0] wd_sel;
  logic [CNT_W-1:0] retired_q;

  mc_controller_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .instr  (instr)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, per-cycle enables/selects and retire strobe
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    npc_op   = NPC_PC4;
    grf_wr   = 1'b0;
    ext_op   = 1'b0;
    alu_op   = ALU_ADD;
    b_sel    = 1'b0;
    dm_wr    = 1'b0;
    a3_sel   = A3_RD;
    wd_sel   = WD_ALU;

    // While reset is held every write is suppressed so an abandoned
    // instruction cannot leave a partial update behind.
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          npc_op  = NPC_PC4;
          state_d = ST_DECODE;
        end

        ST_DECODE: begin
          if (instr.jal) begin
            // PC already holds PC+4, which is the link value
            pc_wr    = 1'b1;
            npc_op   = NPC_JAL;
            grf_wr   = 1'b1;
            a3_sel   = A3_RA;
            wd_sel   = WD_PC;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end else if (instr.jr) begin
            pc_wr    = 1'b1;
            npc_op   = NPC_JR;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end else if (instr.lui) begin
            grf_wr   = 1'b1;
            a3_sel   = A3_RT;
            wd_sel   = WD_LUI;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end else if (instr.illegal) begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
            state_d = ST_HALT;
`else
            state_d = ST_FETCH;
`endif
          end else begin
            state_d = ST_EXE;
          end
        end

        ST_EXE: begin
          state_d = ST_FETCH;
          if (is_rtype_alu(instr)) begin
            alu_op  = instr.subu   ? ALU_SUB :
                      instr.is_xor ? ALU_XOR : ALU_ADD;
            b_sel   = 1'b0;
            state_d = ST_WB;
          end else if (instr.ori) begin
            alu_op  = ALU_OR;
            b_sel   = 1'b1;
            ext_op  = 1'b0;
            state_d = ST_WB;
          end else if (instr.lw || instr.sw) begin
            alu_op  = ALU_ADD;
            b_sel   = 1'b1;
            ext_op  = 1'b1;
            state_d = ST_MEM;
          end else if (instr.beq) begin
            // Branch resolves here; the PC only moves when rs==rt
            alu_op   = ALU_SUB;
            ext_op   = 1'b1;
            npc_op   = NPC_BRANCH;
            pc_wr    = bus.Equ;
            retire_c = 1'b1;
          end
        end

        ST_MEM: begin
          state_d = ST_FETCH;
          if (instr.sw) begin
            dm_wr    = 1'b1;
            ext_op   = 1'b1;
            retire_c = 1'b1;
          end else if (instr.lw) begin
            state_d = ST_WB;
          end
        end

        ST_WB: begin
          grf_wr   = 1'b1;
          a3_sel   = (instr.ori || instr.lw) ? A3_RT : A3_RD;
          wd_sel   = instr.lw ? WD_DM : WD_ALU;
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end

        ST_HALT: begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
          state_d = ST_HALT;
`else
          state_d = ST_FETCH;
`endif
        end

        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (retire_c) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.PCWr  = pc_wr;
  assign bus.IRWr  = ir_wr;
  assign bus.NPCOp = npc_op;
  assign bus.GRFWr = grf_wr;
  assign bus.EXTOp = ext_op;
  assign bus.ALUOp = alu_op;
  assign bus.BSel  = b_sel;
  assign bus.DMWr  = dm_wr;
  assign bus.A3Sel = a3_sel;
  assign bus.WDSel = wd_sel;

  assign state   = STATE_W'(state_q);
  assign retired = retired_q;

`ifdef MC_CTRL_ILLEGAL_HALT_EN
  assign halted = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus process plays an
// instruction stream, pushing the per-cycle control word each instruction
// should produce (from an instruction-level reference table); a monitor pops
// and compares one word per cycle on the falling edge.
module tb_mc_controller;

  localparam int unsigned CNT_W = 32;

  typedef enum int {K_ADDU, K_SUBU, K_XOR, K_ORI, K_LW, K_SW, K_BEQ,
                    K_JAL, K_JR, K_LUI, K_ILL} kind_e;

  typedef struct packed {
    logic             pcwr;
    logic             irwr;
    logic [1:0]       npcop;
    logic             grfwr;
    logic             extop;
    logic [1:0]       aluop;
    logic             bsel;
    logic             dmwr;
    logic [1:0]       a3sel;
    logic [1:0]       wdsel;
    logic [2:0]       state;
    logic             halted;
    logic [CNT_W-1:0] retired;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
  logic halted;
`endif

  mc_controller_if bus ();

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state   (state),
    .retired (retired)
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    ,
    .halted  (halted)
`endif
  );

  always #5 clk = ~clk;

  exp_t             sb_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               check_en = 1'b0;
  logic [CNT_W-1:0] exp_retired = '0;

  // ---------------- reference model (instruction level) ----------------
  function automatic int latency(kind_e k);
    case (k)
      K_JAL, K_JR, K_LUI, K_ILL: return 2;
      K_BEQ:                     return 3;
      K_LW:                      return 5;
      default:                   return 4;
    endcase
  endfunction

  // Control word of cycle 'idx' (0 = fetch) of instruction k
  function automatic exp_t step_word(kind_e k, int idx, bit equ);
    exp_t e = '0;
    case (idx)
      0: begin e.state = 3'd0; e.irwr = 1'b1; e.pcwr = 1'b1; end
      1: begin
        e.state = 3'd1;
        if (k == K_JAL) begin
          e.pcwr = 1'b1; e.npcop = 2'b10; e.grfwr = 1'b1;
          e.a3sel = 2'b10; e.wdsel = 2'b10;
        end else if (k == K_JR) begin
          e.pcwr = 1'b1; e.npcop = 2'b11;
        end else if (k == K_LUI) begin
          e.grfwr = 1'b1; e.a3sel = 2'b01; e.wdsel = 2'b11;
        end
      end
      2: begin
        e.state = 3'd2;
        case (k)
          K_SUBU: e.aluop = 2'b01;
          K_XOR:  e.aluop = 2'b11;
          K_ORI:  begin e.aluop = 2'b10; e.bsel = 1'b1; end
          K_LW, K_SW: begin e.bsel = 1'b1; e.extop = 1'b1; end
          K_BEQ:  begin
            e.aluop = 2'b01; e.extop = 1'b1; e.npcop = 2'b01; e.pcwr = equ;
          end
          default: e.aluop = 2'b00;
        endcase
      end
      3: begin
        if (k == K_LW || k == K_SW) begin
          e.state = 3'd3;
          if (k == K_SW) begin e.dmwr = 1'b1; e.extop = 1'b1; end
        end else begin
          e.state = 3'd4; e.grfwr = 1'b1;
          e.a3sel = (k == K_ORI) ? 2'b01 : 2'b00;
        end
      end
      default: begin
        e.state = 3'd4; e.grfwr = 1'b1; e.a3sel = 2'b01; e.wdsel = 2'b01;
      end
    endcase
    return e;
  endfunction

  function automatic bit legal_op(logic [5:0] op);
    return op inside {6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h03, 6'h0f};
  endfunction

  // MIPS encodings; non-R-type instructions get random low bits in funct
  task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
    op = 6'h00;
    fn = 6'($urandom);
    case (k)
      K_ADDU: fn = 6'h21;
      K_SUBU: fn = 6'h23;
      K_XOR:  fn = 6'h26;
      K_JR:   fn = 6'h08;
      K_ORI:  op = 6'h0d;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2b;
      K_BEQ:  op = 6'h04;
      K_JAL:  op = 6'h03;
      K_LUI:  op = 6'h0f;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          while (fn inside {6'h21, 6'h23, 6'h26, 6'h08}) fn = 6'($urandom);
        end else begin
          op = 6'($urandom);
          while (legal_op(op)) op = 6'($urandom);
        end
      end
    endcase
  endtask

  // ---------------- stimulus helpers (entered at posedge+1) ----------------
  task automatic push(input exp_t e);
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-stream: everything reads zero immediately
  task automatic reset_pulse();
    reset = 1'b0;
    exp_retired = '0;
    for (int i = 0; i < 2; i++) begin
      bus.opcode = 6'($urandom);
      bus.funct  = 6'($urandom);
      push('0);
      next_cycle();
    end
    reset = 1'b1;
  endtask

  // Play one instruction; abort_at >= 0 asserts reset in that cycle instead.
  // equ_sel < 0 picks Equ at random.
  task automatic run_instr(input kind_e k, input int abort_at, input int equ_sel,
                           input logic [5:0] force_op);
    logic [5:0] op;
    logic [5:0] fn;
    bit         equ;
    exp_t       e;
    encode(k, op, fn);
    if (force_op != 6'h00) op = force_op;
    equ = (equ_sel < 0) ? 1'($urandom) : 1'(equ_sel);
    for (int i = 0; i < latency(k); i++) begin
      if (i == abort_at) begin
        reset_pulse();
        return;
      end
      if (i == 0) begin
        // IR still holds the previous word; the controller must not care
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
        bus.Equ    = 1'($urandom);
      end else if (i == 1) begin
        bus.opcode = op;
        bus.funct  = fn;
        bus.Equ    = equ;
      end
      e = step_word(k, i, equ);
      e.retired = exp_retired;
      push(e);
      next_cycle();
    end
    if (k != K_ILL) exp_retired = exp_retired + CNT_W'(1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (check_en) begin
      a.pcwr  = bus.PCWr;   a.irwr  = bus.IRWr;  a.npcop = bus.NPCOp;
      a.grfwr = bus.GRFWr;  a.extop = bus.EXTOp; a.aluop = bus.ALUOp;
      a.bsel  = bus.BSel;   a.dmwr  = bus.DMWr;  a.a3sel = bus.A3Sel;
      a.wdsel = bus.WDSel;  a.state = state;     a.retired = retired;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      a.halted = halted;
`else
      a.halted = 1'b0;
`endif
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow t=%0t got=%h want=<none>", $time, a);
      end else begin
        e = sb_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL ctl_word t=%0t got=%h want=%h (state got %0d want %0d, retired got %0d want %0d)",
                   $time, a, e, a.state, e.state, a.retired, e.retired);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1);
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit allow_ill;
    reset      = 1'b0;
    bus.opcode = '0;
    bus.funct  = '0;
    bus.Equ    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push('0);                 // reset state: all zero, FETCH, retired 0
    check_en = 1'b1;
    next_cycle();
    reset = 1'b1;

    // Directed sequence
    run_instr(K_ADDU, -1, -1, 6'h00);
    run_instr(K_LW,   -1, -1, 6'h00);
    run_instr(K_SW,   -1, -1, 6'h00);
    run_instr(K_BEQ,  -1,  1, 6'h00);
    run_instr(K_BEQ,  -1,  0, 6'h00);
    run_instr(K_JAL,  -1, -1, 6'h00);
    run_instr(K_JR,   -1, -1, 6'h00);
    run_instr(K_LUI,  -1, -1, 6'h00);
    run_instr(K_SUBU, -1, -1, 6'h00);
    run_instr(K_XOR,  -1, -1, 6'h00);
    run_instr(K_ORI,  -1, -1, 6'h00);
    run_instr(K_SW,    3, -1, 6'h00);   // reset lands in MEM of sw
    run_instr(K_ADDU, -1, -1, 6'h00);

`ifdef MC_CTRL_ILLEGAL_HALT_EN
    allow_ill = 1'b0;
`else
    allow_ill = 1'b1;
    run_instr(K_ILL, -1, -1, 6'h3f);
    run_instr(K_ILL, -1, -1, 6'h00);
`endif

    // Randomized stream
    for (int n = 0; n < 80; n++) begin
      kind_e k;
      k = kind_e'($urandom_range(0, allow_ill ? 10 : 9));
      run_instr(k, ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : -1,
                -1, 6'h00);
    end

`ifdef MC_CTRL_ILLEGAL_HALT_EN
    // Illegal opcode parks the FSM until reset
    begin
      exp_t h;
      run_instr(K_ILL, -1, -1, 6'h3f);
      for (int i = 0; i < 12; i++) begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
        h = '0;
        h.state   = 3'd5;
        h.halted  = 1'b1;
        h.retired = exp_retired;
        push(h);
        next_cycle();
      end
      reset_pulse();
      run_instr(K_ORI, -1, -1, 6'h00);
    end
`endif

    check_en = 1'b0;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
